// File: rtl/pasta_keystream_sched.sv
// pasta_keystream_sched: launches PASTA cipher blocks for a keystream job (counter = Ctr0 + i)
//   and serialises each returned block into BITLEN-bit words through a two-slot ping-pong buffer.
// Latency: launch the cycle after an accepted Start_SI; first word valid the cycle after Cph_Finish_SI.
// Backpressure: Ks_Ready_SI low stalls draining; with both slots full, launches wait in HOLD.
// Ports:
//   Clk_CI, Rst_RBI                 clock, async active-low reset
//   Start_SI, Abort_SI              job request / cancel
//   Nonce_DI, Ctr0_DI, NumBlocks_DI job fields, latched on accepted Start_SI
//   Cph_*                           launch/finish interface to the cipher wrapper
//   Ks_Valid_SO/Ks_Ready_SI         keystream word handshake (Ks_Data_DO, Ks_Last_SO)
//   Busy_SO, Done_SO, BlocksDone_DO job status
module pasta_keystream_sched #(
  parameter int PASTA_S = 32,
  parameter int BITLEN  = 17,
  parameter int NB_W    = 16
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RBI,
  input  logic                      Start_SI,
  input  logic                      Abort_SI,
  input  logic [63:0]               Nonce_DI,
  input  logic [63:0]               Ctr0_DI,
  input  logic [NB_W-1:0]           NumBlocks_DI,
  output logic [63:0]               Cph_Nonce_DO,
  output logic [63:0]               Cph_BlockCounter_DO,
  output logic                      Cph_InDataValid_SO,
  input  logic                      Cph_Busy_SI,
  input  logic                      Cph_Finish_SI,
  input  logic [PASTA_S*BITLEN-1:0] Cph_Key_DI,
  output logic                      Ks_Valid_SO,
  input  logic                      Ks_Ready_SI,
  output logic [BITLEN-1:0]         Ks_Data_DO,
  output logic                      Ks_Last_SO,
  output logic                      Busy_SO,
  output logic                      Done_SO,
  output logic [NB_W-1:0]           BlocksDone_DO
);

  localparam int WIDX_W = (PASTA_S > 1) ? $clog2(PASTA_S) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RUN,
    ST_HOLD,
    ST_FLUSH,
    ST_ABORT
  } state_e;

  // Word 0 of a block sits in bits [BITLEN-1:0], so the packed view indexes words directly.
  typedef logic [PASTA_S-1:0][BITLEN-1:0] blk_t;

  state_e            state_q, state_d;
  logic [63:0]       nonce_q;
  logic [63:0]       ctr_q;          // counter of the block currently being (or next to be) launched
  logic [NB_W-1:0]   num_blocks_q;
  logic [NB_W-1:0]   cap_cnt_q;      // blocks captured from the cipher so far
  logic [NB_W-1:0]   blocks_done_q;  // blocks fully drained so far
  blk_t              slot_q [2];
  logic [1:0]        slot_full_q;
  logic              wr_ptr_q;       // slot the next cipher result lands in
  logic              rd_ptr_q;       // slot being drained
  logic [WIDX_W-1:0] word_idx_q;
  logic              done_q, done_d;

  logic              start_acc;
  logic              abort_acc;
  logic              capture;
  logic              ks_hs;
  logic              last_word;
  logic              free_evt;
  logic              job_last;
  logic [NB_W:0]     cap_next;
  logic              more_blocks;
  logic              avail_other;
  logic              avail_wr;
  logic              in_flight;

  assign start_acc = (state_q == ST_IDLE) && Start_SI;
  assign abort_acc = Abort_SI && (state_q != ST_IDLE);
  // Only RUN owns a cipher result; a finish pulse anywhere else (incl. ABORT) is dropped.
  assign capture   = (state_q == ST_RUN) && Cph_Finish_SI && !Abort_SI;

  assign Ks_Valid_SO = slot_full_q[rd_ptr_q];
  assign Ks_Data_DO  = slot_q[rd_ptr_q][word_idx_q];
  assign last_word   = (word_idx_q == WIDX_W'(PASTA_S - 1));
  assign Ks_Last_SO  = Ks_Valid_SO && last_word && (blocks_done_q == num_blocks_q - NB_W'(1));

  // An abort in the same cycle as a handshake wins: the word is not counted as delivered.
  assign ks_hs    = Ks_Valid_SO && Ks_Ready_SI && !abort_acc;
  assign free_evt = ks_hs && last_word;
  assign job_last = ks_hs && Ks_Last_SO;

  assign cap_next    = {1'b0, cap_cnt_q} + {{NB_W{1'b0}}, 1'b1};
  assign more_blocks = cap_next < {1'b0, num_blocks_q};

  // A slot counts as available if it is empty or is being freed this very cycle.
  assign avail_other = !slot_full_q[!wr_ptr_q] || (free_evt && (rd_ptr_q != wr_ptr_q));
  assign avail_wr    = !slot_full_q[wr_ptr_q]  || (free_evt && (rd_ptr_q == wr_ptr_q));

  // A block is outstanding at the cipher if it was launched and its finish is not in this cycle.
  assign in_flight = ((state_q == ST_RUN)   && !Cph_Finish_SI) ||
                     ((state_q == ST_ISSUE) && !Cph_Busy_SI)   ||
                     ((state_q == ST_ABORT) && !Cph_Finish_SI);

  assign Cph_InDataValid_SO  = (state_q == ST_ISSUE) && !Cph_Busy_SI;
  assign Cph_Nonce_DO        = nonce_q;
  assign Cph_BlockCounter_DO = ctr_q;
  assign Busy_SO             = (state_q != ST_IDLE);
  assign Done_SO             = done_q;
  assign BlocksDone_DO       = blocks_done_q;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start_SI) begin
          if (NumBlocks_DI == '0) done_d = 1'b1;
          else                    state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!Cph_Busy_SI) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (Cph_Finish_SI) begin
          if (!more_blocks)     state_d = ST_FLUSH;
          else if (avail_other) state_d = ST_ISSUE;
          else                  state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (avail_wr) state_d = ST_ISSUE;
      end
      ST_FLUSH: begin
        if (job_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_ABORT: begin
        if (Cph_Finish_SI) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything; stay in ABORT only to swallow an outstanding cipher result.
    if (abort_acc) begin
      done_d  = 1'b0;
      state_d = in_flight ? ST_ABORT : ST_IDLE;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      nonce_q       <= '0;
      ctr_q         <= '0;
      num_blocks_q  <= '0;
      cap_cnt_q     <= '0;
      blocks_done_q <= '0;
      slot_full_q   <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      word_idx_q    <= '0;
      for (int i = 0; i < 2; i++) slot_q[i] <= '0;
    end else begin
      if (start_acc) begin
        nonce_q       <= Nonce_DI;
        ctr_q         <= Ctr0_DI;
        num_blocks_q  <= NumBlocks_DI;
        cap_cnt_q     <= '0;
        blocks_done_q <= '0;
        wr_ptr_q      <= 1'b0;
        rd_ptr_q      <= 1'b0;
        word_idx_q    <= '0;
      end
      if (capture) begin
        slot_q[wr_ptr_q]      <= blk_t'(Cph_Key_DI);
        slot_full_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q              <= !wr_ptr_q;
        cap_cnt_q             <= cap_cnt_q + NB_W'(1);
        ctr_q                 <= ctr_q + 64'd1;  // wraps modulo 2^64
      end
      // capture and free never target the same slot: one is empty, the other full.
      if (ks_hs) begin
        if (last_word) begin
          word_idx_q            <= '0;
          slot_full_q[rd_ptr_q] <= 1'b0;
          rd_ptr_q              <= !rd_ptr_q;
          blocks_done_q         <= blocks_done_q + NB_W'(1);
        end else begin
          word_idx_q <= word_idx_q + WIDX_W'(1);
        end
      end
      // Invalidating the slots is enough to clear the buffer; stale data is never presented.
      if (abort_acc) begin
        slot_full_q <= '0;
        wr_ptr_q    <= 1'b0;
        rd_ptr_q    <= 1'b0;
        word_idx_q  <= '0;
      end
    end
  end

endmodule
